sprite_shifter_bank: RTL

//  Parametrised per-scanline sprite output stage: NUM_SPR independent slots, each holding an
//  8-pixel pattern, X countdown, palette and priority. Slots are loaded by indexed valid/ready

---
 rtl/sprite_shifter_bank.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_shifter_bank.sv
// -----------------------------------------------------------------------------
// sprite_shifter_bank
//
// Per-scanline sprite output stage. NUM_SPR independent slots each hold an
// 8-pixel pattern (PLANES bitplanes), an X countdown, a palette and a priority
// bit. During HBLANK the OAM evaluator loads slots in order through a
// valid/ready handshake. During the visible line each i_enable cycle advances
// one pixel. The lowest-index opaque slot wins. Its pixel, palette, priority
// and slot index are registered towards the mixer, together with a sprite-0
// hit flag.
//
// Configuration macro:
//   SPR_HFLIP_EN  when defined, i_ld_hflip=1 bit-reverses every plane at load
//                 time so that pattern bit 7 is shown first. When undefined,
//                 i_ld_hflip is ignored.
//
// Ports:
//   clk            rising-edge clock
//   i_rst_n        synchronous active-low reset (overrides i_ce)
//   i_ce           clock enable; state only changes when high
//   i_line_start   invalidate all slots, rewind load pointer
//   i_enable       advance one pixel this cycle
//   i_ld_valid     load request for next free slot
//   o_ld_ready     slot free and loading permitted (combinational)
//   i_ld_x         pixels to wait before the first sprite pixel
//   i_ld_pat       pattern, plane p = bits [8p+7:8p], bit 0 shown first
//   i_ld_pal       palette bits
//   i_ld_prio      1 = behind background
//   i_ld_hflip     horizontal flip request
//   o_pix          winning pixel (0 = transparent)
//   o_pal          winning palette
//   o_prio         winning priority
//   o_opaque       o_pix != 0
//   o_slot         winning slot index (0 when transparent)
//   o_spr0         slot 0 is opaque this pixel, regardless of winner
//   o_count        number of slots loaded this line
// -----------------------------------------------------------------------------
module sprite_shifter_bank #(
   parameter int NUM_SPR = 8,
   parameter int PLANES  = 2,
   parameter int XW      = 8,
   parameter int PAL_W   = 2,
   localparam int SW     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
   localparam int CW     = $clog2(NUM_SPR + 1)
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  i_ce,
   input  logic                  i_line_start,
   input  logic                  i_enable,
   input  logic                  i_ld_valid,
   output logic                  o_ld_ready,
   input  logic [XW-1:0]         i_ld_x,
   input  logic [PLANES*8-1:0]   i_ld_pat,
   input  logic [PAL_W-1:0]      i_ld_pal,
   input  logic                  i_ld_prio,
   input  logic                  i_ld_hflip,
   output logic [PLANES-1:0]     o_pix,
   output logic [PAL_W-1:0]      o_pal,
   output logic                  o_prio,
   output logic                  o_opaque,
   output logic [SW-1:0]         o_slot,
   output logic                  o_spr0,
   output logic [CW-1:0]         o_count
);

   typedef struct packed {
      logic [XW-1:0]           x;
      logic [3:0]              rem;
      logic [PLANES-1:0][7:0]  pat;
      logic [PAL_W-1:0]        pal;
      logic                    prio;
   } slot_t;

   slot_t                slot_q [NUM_SPR];
   slot_t                slot_d [NUM_SPR];
   logic [NUM_SPR-1:0]   valid_q, valid_d;
   logic [CW-1:0]        ld_ptr_q, ld_ptr_d;
   logic [SW-1:0]        ld_idx;
   logic                 ld_fire;
   logic [PLANES-1:0][7:0] pat_ld;

   logic [PLANES-1:0]    spix [NUM_SPR];
   logic [PLANES-1:0]    pix_d, pix_q;
   logic [PAL_W-1:0]     pal_d, pal_q;
   logic                 prio_d, prio_q;
   logic [SW-1:0]        slot_sel_d, slot_sel_q;
   logic                 spr0_d, spr0_q;
   logic                 opaque_q;

   // Loading is blocked while pixels are shifting and on a line-start cycle,
   // so a load never races an advance or a flush.
   assign o_ld_ready = (ld_ptr_q < CW'(NUM_SPR)) & ~i_enable & ~i_line_start;
   assign ld_fire    = i_ld_valid & o_ld_ready;
   assign ld_idx     = ld_ptr_q[SW-1:0];

`ifdef SPR_HFLIP_EN
   always_comb begin
      pat_ld = i_ld_pat;
      if (i_ld_hflip) begin
         for (int p = 0; p < PLANES; p++) begin
            for (int b = 0; b < 8; b++) begin
               pat_ld[p][b] = i_ld_pat[8*p + 7 - b];
            end
         end
      end
   end
`else
   logic unused_hflip;
   assign unused_hflip = i_ld_hflip;
   assign pat_ld       = i_ld_pat;
`endif

   // Slot next-state: flush, per-pixel advance, and in-order load.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      slot_d   = slot_q;
      valid_d  = valid_q;
      ld_ptr_d = ld_ptr_q;
      if (i_line_start) begin
         valid_d  = '0;
         ld_ptr_d = '0;
      end else begin
         if (i_enable) begin
            for (int i = 0; i < NUM_SPR; i++) begin
               if (valid_q[i]) begin
                  if (slot_q[i].x != '0) begin
                     slot_d[i].x = slot_q[i].x - 1'b1;
                  end else if (slot_q[i].rem != 4'd0) begin
                     for (int p = 0; p < PLANES; p++) begin
                        slot_d[i].pat[p] = {1'b0, slot_q[i].pat[p][7:1]};
                     end
                     slot_d[i].rem = slot_q[i].rem - 4'd1;
                  end
               end
            end
         end
         if (ld_fire) begin
            slot_d[ld_idx].x    = i_ld_x;
            slot_d[ld_idx].rem  = 4'd8;
            slot_d[ld_idx].pat  = pat_ld;
            slot_d[ld_idx].pal  = i_ld_pal;
            slot_d[ld_idx].prio = i_ld_prio;
            valid_d[ld_idx]     = 1'b1;
            ld_ptr_d            = ld_ptr_q + 1'b1;
         end
      end
   end

   // Per-slot pixel from the current (pre-advance) state.
   always_comb begin
      for (int i = 0; i < NUM_SPR; i++) begin
         spix[i] = '0;
         if (valid_q[i] && (slot_q[i].x == '0) && (slot_q[i].rem != 4'd0)) begin
            for (int p = 0; p < PLANES; p++) begin
               spix[i][p] = slot_q[i].pat[p][0];
            end
         end
      end
   end

   // Priority select: scanning from the top down lets the lowest opaque
   // index overwrite any higher one.
   always_comb begin
      pix_d      = '0;
      pal_d      = '0;
      prio_d     = 1'b0;
      slot_sel_d = '0;
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
         if (spix[i] != '0) begin
            pix_d      = spix[i];
            pal_d      = slot_q[i].pal;
            prio_d     = slot_q[i].prio;
            slot_sel_d = SW'(i);
         end
      end
      spr0_d = (spix[0] != '0);
   end

   // Control state and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (!i_rst_n) begin
         valid_q    <= '0;
         ld_ptr_q   <= '0;
         pix_q      <= '0;
         pal_q      <= '0;
         prio_q     <= 1'b0;
         slot_sel_q <= '0;
         spr0_q     <= 1'b0;
         opaque_q   <= 1'b0;
      end else if (i_ce) begin
         valid_q    <= valid_d;
         ld_ptr_q   <= ld_ptr_d;
         pix_q      <= pix_d;
         pal_q      <= pal_d;
         prio_q     <= prio_d;
         slot_sel_q <= slot_sel_d;
         spr0_q     <= spr0_d;
         opaque_q   <= (pix_d != '0);
      end
   end

   // NOTE: slot payload has no reset; it is meaningless while its valid bit
   // is clear, and every load overwrites all of it.
   always_ff @(posedge clk) begin
      if (i_ce) begin
         slot_q <= slot_d;
      end
   end

   assign o_pix    = pix_q;
   assign o_pal    = pal_q;
   assign o_prio   = prio_q;
   assign o_opaque = opaque_q;
   assign o_slot   = slot_sel_q;
   assign o_spr0   = spr0_q;
   assign o_count  = ld_ptr_q;

endmodule
